// File: rtl/bit_ser_pkg.sv
// rtl/bit_ser_pkg.sv - shared types and encodings for the bit-serial adder/subtractor
package bit_ser_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Operation mode encodings, captured from the sub input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/bit_ser_addsub_full_adder.sv
// rtl/bit_ser_addsub_full_adder.sv - single-bit combinational full adder
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the three-way parity; carry is the majority of the inputs
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/bit_ser_addsub.sv
// rtl/bit_ser_addsub.sv - LSB-first bit-serial adder/subtractor with parallel result
module bit_ser_addsub
    import bit_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             sub,
    input  logic             a_bit,
    input  logic             b_bit,
    output logic             sum_bit,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               mode;
    // Holds the WIDTH-1 most recent sum bits; the newest bit is joined
    // on the final edge, so the full sum never needs a discarded position.
    logic [WIDTH-2:0]   sreg;

    logic               b_eff;
    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   shifted;

    // Subtraction inverts B; the +1 comes from the carry preset on start
    always_comb begin
        b_eff   = b_bit ^ mode;
        shifted = {fa_s, sreg};
    end

    full_adder_1b u_fa (
        .a    (a_bit),
        .b    (b_eff),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Controller, carry flop, shift register and registered result flags
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            mode     <= MODE_ADD;
            sreg     <= '0;
            sum_bit  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode  <= sub;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SHIFT: begin
                    carry   <= fa_cout;
                    sum_bit <= fa_s;
                    cnt     <= cnt + CNT_W'(1);
                    sreg    <= shifted[WIDTH-1:1];
                    if (cnt == LAST_CNT) begin
                        // carry still holds the carry into the MSB here
                        result   <= {(mode == MODE_SUB) ? ~fa_cout : fa_cout, shifted};
                        overflow <= carry ^ fa_cout;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_ser_addsub.sv
// tb/tb_bit_ser_addsub.sv - directed self-checking bench for bit_ser_addsub
module tb_bit_ser_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_n;
    logic       start8, sub8, a8, b8, sum8, busy8, done8, ov8;
    logic [8:0] res8;
    logic       start4, sub4, a4, b4, sum4, busy4, done4, ov4;
    logic [4:0] res4;

    bit          sel4;
    logic        cur_sum, cur_busy, cur_done, cur_ov;
    logic [31:0] cur_res;

    int checks   = 0;
    int failures = 0;

    bit_ser_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .clr_n(clr_n), .start(start8), .sub(sub8),
        .a_bit(a8), .b_bit(b8), .sum_bit(sum8), .busy(busy8),
        .done(done8), .result(res8), .overflow(ov8)
    );

    bit_ser_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .clr_n(clr_n), .start(start4), .sub(sub4),
        .a_bit(a4), .b_bit(b4), .sum_bit(sum4), .busy(busy4),
        .done(done4), .result(res4), .overflow(ov4)
    );

    always_comb begin
        cur_sum  = sel4 ? sum4  : sum8;
        cur_busy = sel4 ? busy4 : busy8;
        cur_done = sel4 ? done4 : done8;
        cur_ov   = sel4 ? ov4   : ov8;
        cur_res  = sel4 ? {27'd0, res4} : {23'd0, res8};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sb, input logic a, input logic b);
        if (sel4) begin
            start4 = st; sub4 = sb; a4 = a; b4 = b;
        end else begin
            start8 = st; sub8 = sb; a8 = a; b8 = b;
        end
    endtask

    // One operation on the selected instance; disturb pulses start and flips sub mid-shift
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input bit disturb, input string tag,
                          output logic [31:0] res, output logic ov, output logic [7:0] sseq);
        logic sb;
        sseq = '0;
        @(negedge clk);
        drive(1'b1, s, 1'b0, 1'b0);
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, cur_busy}, 32'd1);
        for (int i = 0; i < w; i++) begin
            sb = (disturb && i >= 3) ? ~s : s;
            drive(disturb && i == 3, sb, a[i], b[i]);
            if (i == w - 1)
                check({tag, "_early_done"}, {31'd0, cur_done}, 32'd0);
            @(negedge clk);
            sseq[i] = cur_sum;
        end
        check({tag, "_done"}, {31'd0, cur_done}, 32'd1);
        res = cur_res;
        ov  = cur_ov;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check({tag, "_strobe"}, {30'd0, cur_done, cur_busy}, 32'd0);
    endtask

    logic [31:0] r;
    logic        o;
    logic [7:0]  sq;
    int          first_done, second_done, t;

    initial begin
        sel4   = 1'b0;
        clr_n  = 1'b0;
        start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
        repeat (2) @(negedge clk);
        check("rst_busy8",   {31'd0, busy8}, 32'd0);
        check("rst_done8",   {31'd0, done8}, 32'd0);
        check("rst_res8",    {23'd0, res8},  32'd0);
        check("rst_ov8",     {31'd0, ov8},   32'd0);
        check("rst_sum8",    {31'd0, sum8},  32'd0);
        check("rst_res4",    {27'd0, res4},  32'd0);
        clr_n = 1'b1;

        // 7 + 3
        run_op(8, 8'h07, 8'h03, 1'b0, 1'b0, "add_07_03", r, o, sq);
        check("add_07_03_res", r, 32'h00A);
        check("add_07_03_ov",  {31'd0, o}, 32'd0);
        check("add_07_03_seq", {24'd0, sq}, 32'h0A);
        check("hold_sum", {31'd0, sum8}, 32'd0);

        run_op(8, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01", r, o, sq);
        check("add_ff_01_res", r, 32'h100);
        check("add_ff_01_ov",  {31'd0, o}, 32'd0);

        run_op(8, 8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01", r, o, sq);
        check("add_7f_01_res", r, 32'h080);
        check("add_7f_01_ov",  {31'd0, o}, 32'd1);

        run_op(8, 8'h05, 8'h07, 1'b1, 1'b0, "sub_05_07", r, o, sq);
        check("sub_05_07_res", r, 32'h1FE);
        check("sub_05_07_ov",  {31'd0, o}, 32'd0);

        run_op(8, 8'h80, 8'h01, 1'b1, 1'b0, "sub_80_01", r, o, sq);
        check("sub_80_01_res", r, 32'h07F);
        check("sub_80_01_ov",  {31'd0, o}, 32'd1);
        check("hold_res", {23'd0, res8}, 32'h07F);

        // start pulse and sub flip during SHIFT are ignored
        run_op(8, 8'h10, 8'h05, 1'b0, 1'b1, "ctl", r, o, sq);
        check("ctl_res", r, 32'h015);
        @(negedge clk);
        check("ctl_no_restart", {30'd0, done8, busy8}, 32'd0);

        // Reset after 4 bits shifted
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy8}, 32'd0);
        check("mid_rst_done", {31'd0, done8}, 32'd0);
        check("mid_rst_res",  {23'd0, res8},  32'd0);
        check("mid_rst_ov",   {31'd0, ov8},   32'd0);
        clr_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) begin
            @(negedge clk);
            if (done8) check("mid_rst_no_done", 32'd1, 32'd0);
        end
        run_op(8, 8'h12, 8'h34, 1'b0, 1'b0, "add_12_34", r, o, sq);
        check("add_12_34_res", r, 32'h046);

        // Start held high: one operation per WIDTH+2 cycles
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        check("b2b_first",  first_done, 32'd8);
        check("b2b_period", second_done - first_done, 32'd10);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        t = 0;
        while ((busy8 || done8) && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("b2b_drain", {31'd0, t < 30}, 32'd1);

        // WIDTH=4 instance
        sel4 = 1'b1;
        run_op(4, 8'h0F, 8'h0F, 1'b0, 1'b0, "w4_add", r, o, sq);
        check("w4_add_res", r, 32'h1E);
        check("w4_add_ov",  {31'd0, o}, 32'd0);
        run_op(4, 8'h00, 8'h01, 1'b1, 1'b0, "w4_sub", r, o, sq);
        check("w4_sub_res", r, 32'h1F);
        check("w4_sub_ov",  {31'd0, o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
